// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit with architectural HI/LO registers for the E stage.
// Operands are latched at start; the result is formed from the latched copies and committed on the final busy edge.
module md_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        md_active,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW         = $clog2(MAX_CYCLES + 1);

    localparam logic [2:0] OP_MTHI = 3'b100;
    localparam logic [2:0] OP_MTLO = 3'b101;

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q,   cnt_d;
    logic [1:0]     op_q,    op_d;     // bit0: unsigned, bit1: divide
    logic [31:0]    a_q,     a_d;
    logic [31:0]    b_q,     b_d;
    logic [31:0]    hi_q,    hi_d;
    logic [31:0]    lo_q,    lo_d;
    logic           busy_q,  busy_d;

    logic               md_start;
    logic               commit;
    logic signed [63:0] prod_s;
    logic [63:0]        prod_u;
    logic               div_zero;
    logic [31:0]        divisor;
    logic signed [31:0] quo_s;
    logic signed [31:0] rem_s;
    logic [31:0]        quo_u;
    logic [31:0]        rem_u;
    logic [63:0]        result;

    // op codes 000..011 are the four arithmetic ops
    assign md_start = start && (op[2] == 1'b0);
    assign commit   = (state_q == RUN) && (cnt_q == CW'(1));

    // A divisor of 1 stands in for zero (result discarded) and for the
    // 0x80000000 / -1 overflow case, where a/1 gives exactly the required answer.
    always_comb begin
        prod_s   = $signed({{32{a_q[31]}}, a_q}) * $signed({{32{b_q[31]}}, b_q});
        prod_u   = {32'd0, a_q} * {32'd0, b_q};
        div_zero = (b_q == 32'd0);
        divisor  = b_q;
        if (div_zero || (a_q == 32'h8000_0000 && b_q == 32'hFFFF_FFFF)) begin
            divisor = 32'd1;
        end
        quo_s = $signed(a_q) / $signed(divisor);
        rem_s = $signed(a_q) % $signed(divisor);
        quo_u = a_q / divisor;
        rem_u = a_q % divisor;
    end

    always_comb begin
        result = 64'd0;
        case (op_q)
            2'b00:   result = prod_s;
            2'b01:   result = prod_u;
            2'b10:   result = {rem_s, quo_s};
            default: result = {rem_u, quo_u};
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        case (state_q)
            IDLE: begin
                if (md_start) begin
                    state_d = RUN;
                    op_d    = op[1:0];
                    a_d     = a;
                    b_d     = b;
                    cnt_d   = op[1] ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
                end else if (start && op == OP_MTHI) begin
                    hi_d = a;
                end else if (start && op == OP_MTLO) begin
                    lo_d = a;
                end
            end
            RUN: begin
                // start is ignored here; the D-stage stall keeps it from happening
                cnt_d = cnt_q - CW'(1);
                if (commit) begin
                    state_d = IDLE;
                    if (!(op_q[1] && div_zero)) begin
                        hi_d = result[63:32];
                        lo_d = result[31:0];
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d == RUN);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            busy_q  <= busy_d;
        end
    end

    assign busy      = busy_q;
    assign md_active = md_start || busy_q;
    assign hi        = hi_q;
    assign lo        = lo_q;

endmodule

// File: tb/tb_md_unit.sv
// Scoreboard bench for md_unit: expected HI/LO and busy length queued at issue, checked when busy falls.
module tb_md_unit;

    localparam int MC = 5;
    localparam int DC = 10;

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;

    logic        clk;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        md_active;
    logic [31:0] hi;
    logic [31:0] lo;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          n;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   run_len  = 0;
    logic busy_prev = 1'b0;

    md_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .op        (op),
        .a         (a),
        .b         (b),
        .busy      (busy),
        .md_active (md_active),
        .hi        (hi),
        .lo        (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic expect_result(input logic [31:0] ehi, input logic [31:0] elo, input int n);
        exp_t e;
        e.hi = ehi;
        e.lo = elo;
        e.n  = n;
        sb.push_back(e);
    endtask

    // Called 1ns after an edge: drive one start cycle, then scramble operands.
    task automatic start_op(input logic [2:0] o, input logic [31:0] va, input logic [31:0] vb,
                            input logic exp_active);
        start = 1'b1;
        op    = o;
        a     = va;
        b     = vb;
        #1;
        check_eq("md_active", {63'd0, md_active}, {63'd0, exp_active});
        @(posedge clk);
        #1;
        start = 1'b0;
        op    = 3'b111;
        a     = $urandom;
        b     = $urandom;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            if (sb.size() == 0) break;
        end
        #1;
        check_eq("drain", 64'(sb.size()), 64'd0);
        sb.delete();
    endtask

    // Monitor: busy falling edge marks a commit; compare against the scoreboard head.
    always @(negedge clk) begin
        if (reset) begin
            busy_prev = 1'b0;
            run_len   = 0;
        end else begin
            if (busy) begin
                run_len++;
            end else if (busy_prev) begin
                if (sb.size() == 0) begin
                    check_eq("spurious_commit", 64'd1, 64'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check_eq("hi", {32'd0, hi}, {32'd0, e.hi});
                    check_eq("lo", {32'd0, lo}, {32'd0, e.lo});
                    check_eq("busy_len", 64'(run_len), 64'(e.n));
                    $display("commit: hi=0x%08h lo=0x%08h busy_len=%0d", hi, lo, run_len);
                end
                run_len = 0;
            end
            busy_prev = busy;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        start = 1'b0;
        op    = 3'b000;
        a     = 32'd0;
        b     = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        check_eq("rst_busy", {63'd0, busy}, 64'd0);
        check_eq("rst_hi", {32'd0, hi}, 64'd0);
        check_eq("rst_lo", {32'd0, lo}, 64'd0);
        check_eq("rst_md_active", {63'd0, md_active}, 64'd0);

        // Signed and unsigned multiply of -3 x 5
        @(posedge clk); #1;
        expect_result(32'hFFFF_FFFF, 32'hFFFF_FFF1, MC);
        start_op(OP_MULT, 32'hFFFF_FFFD, 32'd5, 1'b1);
        check_eq("busy_after_start", {63'd0, busy}, 64'd1);
        wait_idle();
        expect_result(32'h0000_0004, 32'hFFFF_FFF1, MC);
        start_op(OP_MULTU, 32'hFFFF_FFFD, 32'd5, 1'b1);
        wait_idle();

        // Signed divide -7/2, then back-to-back DIVU 7/2 in the first idle cycle
        expect_result(32'hFFFF_FFFF, 32'hFFFF_FFFD, DC);
        start_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, 1'b1);
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (!busy) break;
        end
        check_eq("b2b_idle", {63'd0, busy}, 64'd0);
        check_eq("b2b_lo_visible", {32'd0, lo}, 64'hFFFF_FFFD);
        expect_result(32'd1, 32'd3, DC);
        start_op(OP_DIVU, 32'd7, 32'd2, 1'b1);
        wait_idle();

        // MTHI then divide by zero: full busy period, HI/LO untouched
        start_op(OP_MTHI, 32'h1234_5678, 32'd0, 1'b0);
        check_eq("mthi_hi", {32'd0, hi}, 64'h1234_5678);
        check_eq("mthi_busy", {63'd0, busy}, 64'd0);
        expect_result(32'h1234_5678, 32'd3, DC);
        start_op(OP_DIV, 32'd99, 32'd0, 1'b1);
        wait_idle();

        // MTLO and an undefined op code
        start_op(OP_MTLO, 32'hCAFE_0001, 32'd0, 1'b0);
        check_eq("mtlo_lo", {32'd0, lo}, 64'hCAFE_0001);
        start_op(3'b110, 32'hDEAD_BEEF, 32'd1, 1'b0);
        check_eq("undef_busy", {63'd0, busy}, 64'd0);
        check_eq("undef_hi", {32'd0, hi}, 64'h1234_5678);
        check_eq("undef_lo", {32'd0, lo}, 64'hCAFE_0001);

        // Signed-divide overflow case
        expect_result(32'd0, 32'h8000_0000, DC);
        start_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
        wait_idle();

        // MULT 6x7 with DIVU and MTLO attempted while busy
        expect_result(32'd0, 32'h0000_002A, MC);
        start_op(OP_MULT, 32'd6, 32'd7, 1'b1);
        @(posedge clk); #1;
        start_op(OP_DIVU, 32'd9, 32'd3, 1'b1);
        start_op(OP_MTLO, 32'h0000_DEAD, 32'd0, 1'b1);
        check_eq("ignored_mtlo_lo", {32'd0, lo}, 64'h8000_0000);
        wait_idle();
        repeat (3) @(posedge clk);
        #1;
        check_eq("ignored_divu_busy", {63'd0, busy}, 64'd0);

        // Reset during DIVU 100/3 aborts it; then MULTU 2x3
        expect_result(32'd1, 32'd33, DC);
        start_op(OP_DIVU, 32'd100, 32'd3, 1'b1);
        repeat (3) begin
            @(posedge clk); #1;
        end
        reset = 1'b1;
        sb.delete();
        @(posedge clk); #1;
        reset = 1'b0;
        check_eq("abort_busy", {63'd0, busy}, 64'd0);
        check_eq("abort_hi", {32'd0, hi}, 64'd0);
        check_eq("abort_lo", {32'd0, lo}, 64'd0);
        repeat (15) @(posedge clk);
        #1;
        check_eq("no_late_commit_lo", {32'd0, lo}, 64'd0);
        check_eq("no_late_commit_busy", {63'd0, busy}, 64'd0);
        expect_result(32'd0, 32'd6, MC);
        start_op(OP_MULTU, 32'd2, 32'd3, 1'b1);
        wait_idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
